// File: rtl/buzzer_sched.sv
// Shares one PWM buzzer among three beep requesters, fixed priority with index 0 highest.
// Request pulse to buzz_en high takes two edges; pulses merge while pending, a higher-priority pending request preempts.
module buzzer_sched #(
  parameter int unsigned MS_DIV = 50000,
  parameter logic [31:0] DUTY   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [95:0] req_step,
  input  logic [11:0] req_beeps,
  input  logic [47:0] req_on_ms,
  input  logic [47:0] req_off_ms,
  output logic [31:0] period,
  output logic [31:0] duty,
  output logic        buzz_en,
  output logic        busy,
  output logic [2:0]  grant,
  output logic [2:0]  done
);

  localparam int unsigned DIV_W = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MS_DIV - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t           state, state_nxt;
  logic [2:0]       pending;
  logic [31:0]      step_q;
  logic [3:0]       beeps_q;
  logic [15:0]      on_q, off_q;
  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      ms_cnt;

  logic [1:0]  sel_idx;
  logic [2:0]  sel_oh;
  logic [3:0]  sel_beeps;
  logic [15:0] sel_on, phase_ms;
  logic        take, preempt, expire, last_beep;

  logic [31:0] period_nxt, duty_nxt;
  logic        buzz_nxt, busy_nxt;
  logic [2:0]  grant_nxt, done_nxt;

  always_comb begin
    sel_idx = 2'd0;
    if (!pending[0] && pending[1]) sel_idx = 2'd1;
    else if (!pending[0] && !pending[1]) sel_idx = 2'd2;
  end

  assign sel_oh    = pending & (~pending + 3'd1);
  assign sel_beeps = req_beeps[{sel_idx, 2'd0} +: 4];
  assign sel_on    = req_on_ms[{sel_idx, 4'd0} +: 16];
  assign take      = (state == IDLE) && (pending != 3'd0);
  // grant - 1 masks every index with higher priority than the owner
  assign preempt   = (state != IDLE) && ((pending & (grant - 3'd1)) != 3'd0);
  assign phase_ms  = (state == ON) ? on_q : off_q;
  assign expire    = (state != IDLE) && (div_cnt == DIV_LAST) && (ms_cnt == phase_ms - 16'd1);
  assign last_beep = (beeps_q == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (take) state_nxt = ON;
      ON: begin
        if (preempt) state_nxt = IDLE;
        else if (expire) begin
          if (last_beep)              state_nxt = IDLE;
          else if (off_q == 16'd0)    state_nxt = ON;
          else                        state_nxt = OFF;
        end
      end
      OFF: begin
        if (preempt)     state_nxt = IDLE;
        else if (expire) state_nxt = ON;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    period_nxt = 32'd0;
    duty_nxt   = 32'd0;
    buzz_nxt   = 1'b0;
    busy_nxt   = 1'b0;
    grant_nxt  = 3'd0;
    done_nxt   = 3'd0;
    if (state_nxt != IDLE) begin
      busy_nxt  = 1'b1;
      grant_nxt = take ? sel_oh : grant;
    end
    if (state_nxt == ON) begin
      buzz_nxt   = 1'b1;
      duty_nxt   = DUTY;
      period_nxt = take ? req_step[{sel_idx, 5'd0} +: 32] : step_q;
    end
    if ((state == ON) && expire && last_beep && !preempt) done_nxt = grant;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period  <= 32'd0;
      duty    <= 32'd0;
      buzz_en <= 1'b0;
      busy    <= 1'b0;
      grant   <= 3'd0;
      done    <= 3'd0;
    end else begin
      period  <= period_nxt;
      duty    <= duty_nxt;
      buzz_en <= buzz_nxt;
      busy    <= busy_nxt;
      grant   <= grant_nxt;
      done    <= done_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 3'd0;
      step_q  <= 32'd0;
      beeps_q <= 4'd0;
      on_q    <= 16'd0;
      off_q   <= 16'd0;
      div_cnt <= '0;
      ms_cnt  <= 16'd0;
    end else begin
      // a request arriving in its own grant cycle re-queues: set wins over clear
      pending <= (pending & ~(take ? sel_oh : 3'd0)) | req;
      if (take) begin
        step_q  <= req_step[{sel_idx, 5'd0} +: 32];
        beeps_q <= (sel_beeps == 4'd0) ? 4'd1 : sel_beeps;
        on_q    <= (sel_on == 16'd0) ? 16'd1 : sel_on;
        off_q   <= req_off_ms[{sel_idx, 4'd0} +: 16];
      end else if ((state == ON) && expire && !last_beep && !preempt) begin
        beeps_q <= beeps_q - 4'd1;
      end
      if (take || preempt || expire || (state == IDLE)) begin
        div_cnt <= '0;
        ms_cnt  <= 16'd0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        ms_cnt  <= ms_cnt + 16'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/buzzer_sched.md
Name: buzzer_sched

Overview:
- Scheduler that shares the single PWM buzzer (ax_pwm) between three beep requesters, e.g. key press, access granted and access denied.
- Latches pulsed requests, grants by fixed priority (index 0 highest), and sequences the winner's beep pattern: N beeps, each ON for on_ms, separated by OFF gaps of off_ms.
- Drives ax_pwm period/duty plus a buzzer enable. Replaces the hard-wired single-beep FSM in the top level.

Parameters:
MS_DIV, 50000, clk cycles per 1 ms tick (50 MHz clock); sims use 4
DUTY, 32'h8000_0000, PWM duty word driven while ON (50 %)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req  in  3  one-cycle request pulses, bit i = requester i
req_step  in  96  tone step for ax_pwm, 32 bits per requester, requester i at [32i+31:32i]
req_beeps  in  12  beep count, 4 bits per requester
req_on_ms  in  48  ON time in ms, 16 bits per requester
req_off_ms  in  48  OFF gap in ms, 16 bits per requester
period  out  32  ax_pwm step; 0 when not ON
duty  out  32  ax_pwm duty; DUTY when ON, else 0
buzz_en  out  1  gate for pwm_out, high only in ON
busy  out  1  high while a pattern is active (ON or OFF)
grant  out  3  one-hot, owner of the active pattern; 0 when idle
done  out  3  one-cycle pulse on normal completion of requester i's pattern

Behaviour:
- Reset (async, rst=1): state IDLE; pending=0; all outputs 0; counters 0. Reset mid-pattern drops every pending and active request.
- Pending latch: req[i]=1 sets pending[i] at the clock edge (sticky). Pulses are never lost; repeated pulses while pending merge into one request.
- Pattern capture: pattern fields are sampled at grant time, not at request time. Requesters hold their fields stable while pending.
- States: IDLE, ON, OFF. All outputs are registered.
- IDLE: if pending!=0, select the lowest set index k:
  - clear pending[k];
  - latch step, beeps, on_ms, off_ms for k;
  - grant=onehot(k), busy=1;
  - go to ON.
- Latency: req[k] sampled at edge E; pending visible after E; buzz_en=1 after edge E+1.
- ON: buzz_en=1, period=latched step, duty=DUTY.
  - The ms counter restarts on state entry; ON lasts exactly on_ms*MS_DIV cycles.
  - At expiry, decrement beeps_left. If it was 1: pulse done[k], clear grant/busy/period/duty/buzz_en, go to IDLE. Otherwise go to OFF, or if off_ms=0, restart ON directly with buzz_en held high.
- OFF: buzz_en=0, period=0, duty=0, grant/busy held. Lasts exactly off_ms*MS_DIV cycles, then ON.
- Zero fields: beeps=0 is treated as 1; on_ms=0 is treated as 1.
- Preemption: in ON or OFF, if pending[j] is set with j<k:
  - the current pattern aborts at that edge with no done pulse;
  - requester k is dropped, not re-queued;
  - state goes to IDLE, which grants j on the following edge (one idle cycle, buzz_en=0).
- Equal or lower priority requests wait until the current pattern finishes.
- Simultaneous events:
  - req[k] arriving in the same cycle k is granted: the set wins, so k is re-queued and replays.
  - Completion and a new request in the same cycle: done pulses, and IDLE grants on the next edge.
- Arithmetic: 16-bit ms tick counters and a 4-bit beep counter, no wrap. A full 16-bit on_ms (65535 ms) is legal.

Test Plan (MS_DIV=4):
- Single request: req[1] pulse with step=8590, beeps=2, on=3, off=2 -> buzz_en high 12 cycles, low 8, high 12. period=8590 only while high. done[1] pulses once, in the cycle after the second ON ends. grant=3'b010 throughout.
- Priority: req[2] and req[0] pulsed in the same cycle -> requester 0's pattern runs first, then requester 2's after one idle cycle. done[0] comes before done[2].
- Preemption: req[0] pulsed during requester 2's OFF phase -> grant goes 100 -> 000 for one cycle -> 001. No done[2] ever. Requester 0 plays a full pattern.
- Zero fields: beeps=0, on=0, off=0 -> exactly one ON of 4 cycles, then done. A second case with beeps=3, off=0 -> buzz_en continuously high for 3*on_ms*4 cycles.
- Pending merge / re-queue: three req[1] pulses while requester 1 is pending -> one pattern plays. req[1] pulsed in its own grant cycle -> the pattern plays twice.
- Async reset asserted mid-ON, with pending bits set -> all outputs 0 immediately with no clk edge. After release, no pattern plays until a new req.
